// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional FAULT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC      = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    ST_FAULT
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding buffer for a response that arrives while the
// output slot is stalled with a valid instruction.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic         full_o
);

  fetch_entry_t data_q;
  logic         full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (push_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generation and instruction-memory fetch feeding the IF/ID register.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module instruction_fetch_unit
  import fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] f_instruction_o,
  output logic [XLEN-1:0] f_pc_o,
  output logic [XLEN-1:0] f_pcsrc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            f_misalign_o,
`endif
  output logic            f_valid_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            drop_q, drop_d;
  fetch_entry_t    out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] pcsrc_q, pcsrc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  logic            req_c;
  logic            accept_c;
  logic            outstanding_c;
  logic            skid_push_c, skid_pop_c, skid_flush_c;
  logic            skid_full;
  fetch_entry_t    skid_entry;
  fetch_entry_t    resp_entry;
  logic [XLEN-1:0] target_c;

  fetch_skid_buffer u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (skid_push_c),
    .pop_i   (skid_pop_c),
    .flush_i (skid_flush_c),
    .data_i  (resp_entry),
    .data_o  (skid_entry),
    .full_o  (skid_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      infl_pc_q   <= RESET_PC;
      drop_q      <= 1'b0;
      out_q       <= '{instr: NOP_INSTR, pc: RESET_PC};
      out_valid_q <= 1'b0;
      pcsrc_q     <= RESET_PC + PC_INC;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_pc_q   <= infl_pc_d;
      drop_q      <= drop_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pcsrc_q     <= pcsrc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    infl_pc_d    = infl_pc_q;
    drop_d       = drop_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    req_c        = 1'b0;
    skid_push_c  = 1'b0;
    skid_pop_c   = 1'b0;
    skid_flush_c = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
    target_c     = redirect_pc_i;
`else
    target_c     = redirect_pc_i & PC_ALIGN_MASK;
`endif
    resp_entry    = '{instr: imem_rdata_i, pc: infl_pc_q};
    accept_c      = (state_q == ST_WAIT) && imem_rvalid_i && !drop_q && !redirect_i;
    outstanding_c = (state_q == ST_WAIT) && !imem_rvalid_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state_q == ST_FAULT && drop_q && !imem_rvalid_i) outstanding_c = 1'b1;
`endif

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        req_c = !skid_full;
        if (req_c && imem_gnt_i) begin
          infl_pc_d = pc_q;
          pc_d      = pc_q + PC_INC;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            // back-to-back issue only when the response lands in the slot
            req_c = accept_c && (!out_valid_q || !stall_i);
            if (req_c && imem_gnt_i) begin
              infl_pc_d = pc_q;
              pc_d      = pc_q + PC_INC;
              state_d   = ST_WAIT;
            end
          end
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: if (imem_rvalid_i) drop_d = 1'b0;
`endif
      default: state_d = ST_IDLE;
    endcase

    // output slot: skid drains first, a stalled valid slot diverts into the skid
    if (!stall_i) begin
      if (skid_full) begin
        out_d       = skid_entry;
        out_valid_d = 1'b1;
        skid_pop_c  = 1'b1;
      end else if (accept_c) begin
        out_d       = resp_entry;
        out_valid_d = 1'b1;
      end else begin
        out_d.instr = NOP_INSTR;
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (!out_valid_q) begin
        out_d       = resp_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_push_c = 1'b1;
      end
    end

    if (redirect_i) begin
      pc_d         = target_c;
      out_d.instr  = NOP_INSTR;
      out_valid_d  = 1'b0;
      skid_flush_c = 1'b1;
      skid_push_c  = 1'b0;
      skid_pop_c   = 1'b0;
      drop_d       = outstanding_c || (req_c && imem_gnt_i);
      state_d      = drop_d ? ST_WAIT : ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d   = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d    = ST_FAULT;
        out_d.pc   = redirect_pc_i;
        misalign_d = 1'b1;
      end
`endif
    end

    pcsrc_d = out_d.pc + PC_INC;
  end

  assign imem_req_o      = req_c;
  assign imem_addr_o     = pc_q;
  assign f_instruction_o = out_q.instr;
  assign f_pc_o          = out_q.pc;
  assign f_pcsrc_o       = pcsrc_q;
  assign f_valid_o       = out_valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign f_misalign_o    = misalign_q;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Producer side of the IF/ID pipeline register. Generates the program counter and fetches instructions over a request/grant/response instruction-memory interface. Delivers instruction, PC, and PC+4 with a valid flag into the fetch–decode register. Honours a stall from the hazard unit and a redirect (branch/jump target) from execute, and discards in-flight responses made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, instruction presented while the output slot is invalid or flushed
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, always equal to pc_q
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; at most one response per granted request, in order
- imem_rdata_i  in  32  response instruction word
- stall_i  in  1  hold all f_* outputs
- redirect_i  in  1  discard the current stream and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  redirect target
- f_instruction_o  out  32  instruction to IF/ID
- f_pc_o  out  32  PC of f_instruction_o
- f_pcsrc_o  out  32  f_pc_o + 4, modulo 2^32
- f_valid_o  out  1  output slot holds a real instruction
- f_misalign_o  out  1  misaligned redirect fault; present only with FETCH_MISALIGN_CHECK_EN

## Operation
- **Registers**
  - pc_q: next request address.
  - infl_pc_q: PC of the in-flight request.
  - drop_q: the in-flight response must be discarded.
  - Output slot registers.
  - One-entry skid buffer.
- **FSM states:** IDLE, REQ, WAIT, FAULT (FAULT only exists with the macro).
- **IDLE:** entered on reset; moves to REQ on the next cycle. A response arriving in IDLE is ignored.
- **REQ:** imem_req_o = 1. On imem_gnt_i: infl_pc_q <= pc_q, pc_q <= pc_q + 4, go to WAIT.
- **WAIT:** waits for imem_rvalid_i. The response is accepted as follows:
  - drop_q = 1: the response is discarded and drop_q is cleared.
  - Output slot empty, or stall_i = 0: the response goes to the output slot.
  - Otherwise: the response goes to the skid buffer.
- **Back-to-back issue:** in the rvalid cycle, if the response is accepted into the output slot and there is no redirect, imem_req_o = 1 for pc_q in that same cycle. On grant the FSM stays in WAIT; with no grant it goes to REQ.
- **Skid full:** no request is issued (stay in or return to REQ with imem_req_o = 0) until the skid drains.
- **Output slot update when stall_i = 0:**
  - The slot takes the skid contents if the skid is full, else the accepted response.
  - If neither is available, the slot becomes invalid: f_valid_o = 0 and f_instruction_o = NOP_INSTR.
- **Stall hold:** while stall_i = 1 and f_valid_o = 1, every f_* output holds. If f_valid_o = 0, a response may fill the slot even while stalled.
- **Redirect (priority over stall and everything else):**
  - pc_q <= redirect_pc_i.
  - The output slot and skid are invalidated (NOP_INSTR, valid 0).
  - If a request is in flight, or is granted in the redirect cycle, drop_q <= 1.
  - FSM goes to REQ. While drop_q = 1, the FSM stays in WAIT for the stale response before issuing the new request.
- **Redirect coinciding with rvalid:** that response is discarded and drop_q is unaffected.
- **PC arithmetic:** 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.

## Timing
- **Reset values:**
  - imem_req_o = 0; imem_addr_o = RESET_PC.
  - f_valid_o = 0; f_instruction_o = NOP_INSTR.
  - f_pc_o = RESET_PC; f_pcsrc_o = RESET_PC + 4.
  - f_misalign_o = 0; FSM in IDLE; drop_q = 0; skid empty.
- **First fetch:** first request in cycle 1 after reset deasserts.
- **Latency:** the output slot is valid the cycle after rvalid. With a grant at t and rvalid at t+1, f_valid_o rises at t+2.
- **Throughput:** one instruction per cycle with single-cycle memory and no stall.
- **Redirect penalty:** with redirect at t, the new request is at t+1 if nothing is in flight, else the cycle after the stale response.
- **Reset mid-transaction:** all state is cleared, and responses arriving after reset while in IDLE are ignored.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 enters FAULT.
  - In FAULT: no requests, f_valid_o = 0, f_misalign_o = 1, and f_pc_o = the offending target.
  - FAULT is left only on the next redirect or on reset.
- Not defined: f_misalign_o is absent, and redirect_pc_i[1:0] is forced to 2'b00.

## Structure
- Package fetch_pkg: FSM state enum, NOP_INSTR default, XLEN = 32, PC increment constant 4.
- Sub-module fetch_skid_buffer: one-entry {instr, pc} buffer with push, pop, flush, and full.

## Test plan
- **Reset, zero-wait memory returning 32'h00500093 at 0x0:** grant in cycle 1 and rvalid in cycle 2 must give f_valid_o = 1, f_pc_o = 0x0, f_pcsrc_o = 0x4 in cycle 3, then consecutive PCs 0x4 and 0x8 on following cycles.
- **stall_i held 3 cycles while valid:** f_* outputs frozen. The next response is captured in the skid and no new request is issued. After stall release, the skid instruction appears the next cycle with no loss or duplication.
- **Redirect to 0x100 while the request for 0x8 is in flight:** the 0x8 response is discarded, the next request address is 0x100, and no instruction with PC 0x8 ever shows f_valid_o = 1.
- **Redirect and stall_i asserted in the same cycle:** redirect wins. The output becomes NOP_INSTR with valid 0, and fetch resumes at the target.
- **PC wrap:** redirect to 0xFFFFFFFC must give f_pc_o = 0xFFFFFFFC, f_pcsrc_o = 0x0, and a next request at 0x0.
- **With FETCH_MISALIGN_CHECK_EN, redirect to 0x102:** f_misalign_o = 1, no imem_req_o, and f_pc_o = 0x102. A following redirect to 0x200 clears the fault and resumes fetch.
